walk_button_sync: RTL

//   Front end of the pedestrian-request path: synchronises the raw asynchronous

---
 rtl/walk_button_sync.sv | 110 +++++++++++
 1 files changed

// File: rtl/walk_button_sync.sv
// Walk push-button front end: 2-FF synchroniser, debounce FSM and a single-cycle
// request pulse per accepted press; Button_Held reflects the debounced pressed level.
`timescale 1us/1ns
module walk_button_sync #(
    parameter int unsigned  DEBOUNCE_CYCLES = 4,
    localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic Walk_Button,
    output logic Sync_WalkReq,
    output logic Button_Held
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } state_e;

    logic             btn_s1_q;
    logic             btn_s2_q;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             held_q;
    logic             held_d;

    // Two-stage synchroniser; only btn_s2_q is used downstream.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            btn_s1_q <= Walk_Button;
            btn_s2_q <= btn_s1_q;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    // Debounce: a level must stay stable for DEBOUNCE_CYCLES checks to be accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s2_q) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (btn_s2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == PRESSED) || (state_d == REL_CHK);
    end

    assign Sync_WalkReq = pulse_q;
    assign Button_Held  = held_q;

endmodule
